// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and constants for the debounced button array.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

   localparam int SYSCLOCK_FREQ = 100_000_000;

   typedef enum logic [1:0] {
      ST_IDLE            = 2'd0,
      ST_CONFIRM_PRESS   = 2'd1,
      ST_HELD            = 2'd2,
      ST_CONFIRM_RELEASE = 2'd3
   } btn_state_t;

   // One width serves both counters so that neither can wrap.
   function automatic int cnt_width(input int debounce, input int long_press);
      return $clog2(((debounce > long_press) ? debounce : long_press) + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_array_if.sv
`default_nettype none
// ============================================================================
// Module      : button_array_if
// Description : Pin inputs and debounced event outputs of the button array.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_array_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] pin;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] press;
   // "release" is a reserved word, hence the suffix.
   logic [CHANNELS-1:0] release_pulse;
   logic [CHANNELS-1:0] long_press;

   modport master (
      output pin,
      input  level, press, release_pulse, long_press
   );

   modport slave (
      input  pin,
      output level, press, release_pulse, long_press
   );
endinterface
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button: 2-flop synchronizer, debounce FSM, long-press
//               timer (timer present only with BUTTON_LONG_PRESS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
   import button_pkg::*;
#(
   parameter logic ACTIVE_HIGH       = 1'b1,
   parameter int   DEBOUNCE_CYCLES   = 1000000,
   parameter int   LONG_PRESS_CYCLES = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long_press
);

   localparam int                 c_CNT_W   = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
   localparam logic [c_CNT_W-1:0] c_DEB_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

   logic               r_sync1;
   logic               r_sync2;
   logic               w_s;
   btn_state_t         r_state;
   btn_state_t         w_state_nxt;
   logic [c_CNT_W-1:0] r_deb_cnt;
   logic [c_CNT_W-1:0] w_deb_cnt_nxt;
   logic               w_level_nxt;
   logic               w_press_nxt;
   logic               w_release_nxt;
   logic               r_level;
   logic               r_press;
   logic               r_release;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= ~ACTIVE_HIGH;
         r_sync2 <= ~ACTIVE_HIGH;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = (r_sync2 == ACTIVE_HIGH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_deb_cnt <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_deb_cnt <= w_deb_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_deb_cnt_nxt = r_deb_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_s) begin
               w_state_nxt   = ST_CONFIRM_PRESS;
               w_deb_cnt_nxt = c_ONE;
            end
         end
         ST_CONFIRM_PRESS: begin
            if (!w_s) begin
               w_state_nxt   = ST_IDLE;
               w_deb_cnt_nxt = '0;
            end else if (r_deb_cnt == c_DEB_MAX) begin
               w_state_nxt   = ST_HELD;
               w_deb_cnt_nxt = '0;
               w_press_nxt   = 1'b1;
            end else begin
               w_deb_cnt_nxt = r_deb_cnt + c_ONE;
            end
         end
         ST_HELD: begin
            if (!w_s) begin
               w_state_nxt   = ST_CONFIRM_RELEASE;
               w_deb_cnt_nxt = c_ONE;
            end
         end
         ST_CONFIRM_RELEASE: begin
            // A bounce back to HELD is silent: the press was already reported.
            if (w_s) begin
               w_state_nxt   = ST_HELD;
               w_deb_cnt_nxt = '0;
            end else if (r_deb_cnt == c_DEB_MAX) begin
               w_state_nxt   = ST_IDLE;
               w_deb_cnt_nxt = '0;
               w_release_nxt = 1'b1;
            end else begin
               w_deb_cnt_nxt = r_deb_cnt + c_ONE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_deb_cnt_nxt = '0;
         end
      endcase
      w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_CONFIRM_RELEASE);
   end

`ifdef BUTTON_LONG_PRESS_EN
   localparam logic [c_CNT_W-1:0] c_LONG_MAX = c_CNT_W'(LONG_PRESS_CYCLES);

   logic [c_CNT_W-1:0] r_long_cnt;
   logic               r_long_press;

   // Runs while level is 1 (including CONFIRM_RELEASE), saturates at the limit.
   always_ff @(posedge clk) begin
      if (reset || !w_level_nxt) begin
         r_long_cnt   <= '0;
         r_long_press <= 1'b0;
      end else if (r_level && (r_long_cnt != c_LONG_MAX)) begin
         r_long_cnt   <= r_long_cnt + c_ONE;
         r_long_press <= (r_long_cnt == (c_LONG_MAX - c_ONE));
      end else begin
         r_long_press <= 1'b0;
      end
   end

   assign o_long_press = r_long_press;
`else
   assign o_long_press = 1'b0;
`endif

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/button_array.sv
`default_nettype none
// ============================================================================
// Module      : button_array
// Description : CHANNELS independent debounced buttons with press/release/
//               long-press pulses. Long press enabled by BUTTON_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_array
   import button_pkg::*;
#(
   parameter int                  CHANNELS          = 4,
   parameter logic [CHANNELS-1:0] ACTIVE_MASK       = '1,
   parameter int                  DEBOUNCE_CYCLES   = 1000000,
   parameter int                  LONG_PRESS_CYCLES = 100000000
) (
   input  logic           clk,
   input  logic           reset,
   button_array_if.slave  bus
);

   logic [CHANNELS-1:0] w_level;
   logic [CHANNELS-1:0] w_press;
   logic [CHANNELS-1:0] w_release;
   logic [CHANNELS-1:0] w_long_press;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
         button_channel #(
            .ACTIVE_HIGH       (ACTIVE_MASK[gi]),
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
         ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .i_pin        (bus.pin[gi]),
            .o_level      (w_level[gi]),
            .o_press      (w_press[gi]),
            .o_release    (w_release[gi]),
            .o_long_press (w_long_press[gi])
         );
      end
   endgenerate

   assign bus.level         = w_level;
   assign bus.press         = w_press;
   assign bus.release_pulse = w_release;
   assign bus.long_press    = w_long_press;

endmodule
`default_nettype wire

// File: tb/tb_button_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_array
// Description : Directed self-checking bench for button_array (4 channels,
//               mask 0101, debounce 8, long press 20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_array;

   localparam int         CH        = 4;
   localparam logic [3:0] MASK      = 4'b0101;
   localparam logic [3:0] IDLE_PINS = 4'b1010;
`ifdef BUTTON_LONG_PRESS_EN
   localparam int         LONG_EN   = 1;
`else
   localparam int         LONG_EN   = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   button_array_if #(.CHANNELS(CH)) bus ();

   button_array #(
      .CHANNELS          (CH),
      .ACTIVE_MASK       (MASK),
      .DEBOUNCE_CYCLES   (8),
      .LONG_PRESS_CYCLES (20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] lvl, input logic [3:0] pr,
                                input logic [3:0] rl, input logic [3:0] lp);
      check_eq({tag, ".level"},   32'(bus.level),         32'(lvl));
      check_eq({tag, ".press"},   32'(bus.press),         32'(pr));
      check_eq({tag, ".release"}, 32'(bus.release_pulse), 32'(rl));
      check_eq({tag, ".long"},    32'(bus.long_press),    32'(lp));
   endtask

   // Edge 0 is the first rising edge after the pins were last driven; -1 = no event.
   task automatic run_seg(input string tag, input int n,
                          input logic [3:0] lvl_before, input logic [3:0] lvl_after, input int lvl_edge,
                          input int press_edge, input logic [3:0] press_mask,
                          input int rel_edge,   input logic [3:0] rel_mask,
                          input int long_edge,  input logic [3:0] long_mask);
      for (int e = 0; e < n; e++) begin
         tick();
         check_outputs($sformatf("%s@%0d", tag, e),
                       (lvl_edge >= 0 && e >= lvl_edge) ? lvl_after : lvl_before,
                       (e == press_edge) ? press_mask : 4'b0000,
                       (e == rel_edge)   ? rel_mask   : 4'b0000,
                       (e == long_edge)  ? long_mask  : 4'b0000);
      end
   endtask

   initial begin
      reset   = 1'b1;
      bus.pin = IDLE_PINS;
      repeat (3) tick();
      check_outputs("reset", 4'b0, 4'b0, 4'b0, 4'b0);
      reset = 1'b0;
      run_seg("idle", 3, 4'b0, 4'b0, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);

      // Active-high channel 0: press at edge 10, release 10 edges after return.
      bus.pin = 4'b1011;
      run_seg("t1_press", 16, 4'b0000, 4'b0001, 10, 10, 4'b0001, -1, 4'b0, -1, 4'b0);
      bus.pin = IDLE_PINS;
      run_seg("t1_rel", 12, 4'b0001, 4'b0000, 10, -1, 4'b0, 10, 4'b0001, -1, 4'b0);

      // Five-cycle glitch on channel 2 is rejected.
      bus.pin = 4'b1110;
      run_seg("t2_glitch", 5, 4'b0, 4'b0, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);
      bus.pin = IDLE_PINS;
      run_seg("t2_after", 12, 4'b0, 4'b0, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);

      // Active-low channel 1 held 30 cycles: long press 20 edges after press.
      bus.pin = 4'b1000;
      run_seg("t3_press", 30, 4'b0000, 4'b0010, 10, 10, 4'b0010, -1, 4'b0, -1, 4'b0);
      bus.pin = IDLE_PINS;
      run_seg("t3_rel", 14, 4'b0010, 4'b0000, 10, -1, 4'b0, 10, 4'b0010,
              (LONG_EN != 0) ? 0 : -1, 4'b0010);

      // Channels 0 and 3 together.
      bus.pin = 4'b0011;
      run_seg("t4_press", 12, 4'b0000, 4'b1001, 10, 10, 4'b1001, -1, 4'b0, -1, 4'b0);
      bus.pin = IDLE_PINS;
      run_seg("t4_rel", 12, 4'b1001, 4'b0000, 10, -1, 4'b0, 10, 4'b1001, -1, 4'b0);

      // Reset while channel 0 is mid-confirm (count 5 after edge 6).
      bus.pin = 4'b1011;
      run_seg("t5_pre", 7, 4'b0, 4'b0, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);
      reset = 1'b1;
      tick();
      check_outputs("t5_reset", 4'b0, 4'b0, 4'b0, 4'b0);
      reset = 1'b0;
      run_seg("t5_press", 14, 4'b0000, 4'b0001, 10, 10, 4'b0001, -1, 4'b0, -1, 4'b0);

      // Short release bounce: level stays, no pulses; long press still counts.
      bus.pin = IDLE_PINS;
      run_seg("t6_low", 3, 4'b0001, 4'b0001, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);
      bus.pin = 4'b1011;
      run_seg("t6_back", 12, 4'b0001, 4'b0001, -1, -1, 4'b0, -1, 4'b0, -1, 4'b0);
      run_seg("t6_long", 4, 4'b0001, 4'b0001, -1, -1, 4'b0, -1, 4'b0,
              (LONG_EN != 0) ? 1 : -1, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
